// File: rtl/serial_cmd_scheduler.sv
// Command FIFO plus packet sequencer that feeds a serial transmitter: it holds payload,
// per-bit speed and idle mode stable for each packet and steps the speed select bit by bit.
module serial_cmd_scheduler #(
   parameter int DATA_BIT   = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_CYCLES = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          i_wr_en,
   input  logic [DATA_BIT-1:0]           i_wr_data,
   input  logic [DATA_BIT-1:0]           i_wr_speed_mask,
   input  logic [1:0]                    i_wr_idle_mode,
   input  logic                          i_abort,
   input  logic                          i_bit_tick,
   input  logic                          i_done_tick,
   output logic                          o_start,
   output logic                          o_stop,
   output logic                          o_sel_freq,
   output logic [DATA_BIT-1:0]           o_data,
   output logic [1:0]                    o_idle_mode,
   output logic                          o_full,
   output logic                          o_empty,
   output logic [$clog2(FIFO_DEPTH):0]   o_count,
   output logic                          o_busy,
   output logic                          o_pkt_done_tick,
   output logic                          o_wr_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam int EW = 2 * DATA_BIT + 2;
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BIT - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [1:0]    MODE_REPEAT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND,
      ST_GAP
   } state_t;

   state_t                state_q, state_d;
   logic [EW-1:0]         mem_q [FIFO_DEPTH];
   logic [EW-1:0]         mem_d [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic [DATA_BIT-1:0]   data_q, data_d;
   logic [DATA_BIT-1:0]   mask_q, mask_d;
   logic [1:0]            mode_q, mode_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic                  sel_q, sel_d;
   logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
   logic                  start_q, start_d;
   logic                  stop_q, stop_d;
   logic                  pkt_done_q, pkt_done_d;
   logic                  wr_err_q, wr_err_d;

   logic [EW-1:0]         head;
   logic [DATA_BIT-1:0]   head_mask;
   logic [IW-1:0]         idx_nxt;
   logic                  push;
   logic                  pop;

   assign head      = mem_q[rd_ptr_q];
   assign head_mask = head[DATA_BIT+1:2];
   assign idx_nxt   = idx_q + 1'b1;
   // Fullness is judged on the registered flag, so a pop in the same clock never frees room.
   assign push      = i_wr_en && !full_q && !i_abort;
   assign pop       = (state_q == ST_LOAD) && !i_abort;

   always_comb begin
      state_d    = state_q;
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      data_d     = data_q;
      mask_d     = mask_q;
      mode_d     = mode_q;
      idx_d      = idx_q;
      sel_d      = sel_q;
      gap_cnt_d  = gap_cnt_q;
      start_d    = 1'b0;
      stop_d     = 1'b0;
      pkt_done_d = 1'b0;
      wr_err_d   = i_wr_en && full_q && !i_abort;

      if (push) begin
         mem_d[wr_ptr_q] = {i_wr_data, i_wr_speed_mask, i_wr_idle_mode};
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);

      case (state_q)
         ST_IDLE: begin
            if (!empty_q) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            data_d  = head[EW-1:DATA_BIT+2];
            mask_d  = head_mask;
            mode_d  = head[1:0];
            idx_d   = '0;
            sel_d   = head_mask[0];
            start_d = 1'b1;
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (i_done_tick) begin
               pkt_done_d = 1'b1;
               if (mode_q != MODE_REPEAT) begin
                  state_d   = ST_GAP;
                  gap_cnt_d = '0;
               end else if (!empty_q) begin
                  stop_d    = 1'b1;
                  state_d   = ST_GAP;
                  gap_cnt_d = '0;
               end else begin
                  idx_d = '0;
                  sel_d = mask_q[0];
               end
            end else if (i_bit_tick && (idx_q < IDX_LAST)) begin
               idx_d = idx_nxt;
               sel_d = mask_q[idx_nxt];
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort overrides everything above: queue flushed, any pending write dropped silently.
      if (i_abort) begin
         state_d    = ST_IDLE;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         gap_cnt_d  = '0;
         start_d    = 1'b0;
         pkt_done_d = 1'b0;
         stop_d     = (state_q == ST_SEND);
      end

      full_d  = (count_d == CW'(FIFO_DEPTH));
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         data_q     <= '0;
         mask_q     <= '0;
         mode_q     <= 2'b00;
         idx_q      <= '0;
         sel_q      <= 1'b0;
         gap_cnt_q  <= '0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
         pkt_done_q <= 1'b0;
         wr_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         data_q     <= data_d;
         mask_q     <= mask_d;
         mode_q     <= mode_d;
         idx_q      <= idx_d;
         sel_q      <= sel_d;
         gap_cnt_q  <= gap_cnt_d;
         start_q    <= start_d;
         stop_q     <= stop_d;
         pkt_done_q <= pkt_done_d;
         wr_err_q   <= wr_err_d;
      end
   end

   assign o_start         = start_q;
   assign o_stop          = stop_q;
   assign o_sel_freq      = sel_q;
   assign o_data          = data_q;
   assign o_idle_mode     = mode_q;
   assign o_full          = full_q;
   assign o_empty         = empty_q;
   assign o_count         = count_q;
   assign o_busy          = (state_q != ST_IDLE);
   assign o_pkt_done_tick = pkt_done_q;
   assign o_wr_err        = wr_err_q;

endmodule

// File: tb/tb_serial_cmd_scheduler.sv
// Directed bench for serial_cmd_scheduler with default parameters (8-bit packets, depth 4, gap 2).
module tb_serial_cmd_scheduler;

   logic       clk;
   logic       rst_n;
   logic       i_wr_en;
   logic [7:0] i_wr_data;
   logic [7:0] i_wr_speed_mask;
   logic [1:0] i_wr_idle_mode;
   logic       i_abort;
   logic       i_bit_tick;
   logic       i_done_tick;
   logic       o_start;
   logic       o_stop;
   logic       o_sel_freq;
   logic [7:0] o_data;
   logic [1:0] o_idle_mode;
   logic       o_full;
   logic       o_empty;
   logic [2:0] o_count;
   logic       o_busy;
   logic       o_pkt_done_tick;
   logic       o_wr_err;

   int testsRun = 0;
   int testsFailed = 0;

   serial_cmd_scheduler #(
      .DATA_BIT  (8),
      .FIFO_DEPTH(4),
      .GAP_CYCLES(2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_wr_en        (i_wr_en),
      .i_wr_data      (i_wr_data),
      .i_wr_speed_mask(i_wr_speed_mask),
      .i_wr_idle_mode (i_wr_idle_mode),
      .i_abort        (i_abort),
      .i_bit_tick     (i_bit_tick),
      .i_done_tick    (i_done_tick),
      .o_start        (o_start),
      .o_stop         (o_stop),
      .o_sel_freq     (o_sel_freq),
      .o_data         (o_data),
      .o_idle_mode    (o_idle_mode),
      .o_full         (o_full),
      .o_empty        (o_empty),
      .o_count        (o_count),
      .o_busy         (o_busy),
      .o_pkt_done_tick(o_pkt_done_tick),
      .o_wr_err       (o_wr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic wr, input logic [7:0] data, input logic [7:0] mask,
                                input logic [1:0] mode, input logic bt, input logic dt,
                                input logic ab);
      i_wr_en         = wr;
      i_wr_data       = data;
      i_wr_speed_mask = mask;
      i_wr_idle_mode  = mode;
      i_bit_tick      = bt;
      i_done_tick     = dt;
      i_abort         = ab;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      applyStimulus(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [7:0] m;
      rst_n = 1'b0;
      quiet();
      #12;
      checkOutput("rst_empty", o_empty, 1);
      checkOutput("rst_full", o_full, 0);
      checkOutput("rst_count", o_count, 0);
      checkOutput("rst_busy", o_busy, 0);
      checkOutput("rst_start", o_start, 0);
      checkOutput("rst_data", o_data, 0);
      checkOutput("rst_wr_err", o_wr_err, 0);
      rst_n = 1'b1;
      tick();

      // Single packet, all bits high speed
      applyStimulus(1'b1, 8'h55, 8'hFF, 2'b01, 1'b0, 1'b0, 1'b0);
      tick();
      quiet();
      checkOutput("p1_count_after_wr", o_count, 1);
      checkOutput("p1_empty_after_wr", o_empty, 0);
      checkOutput("p1_start_early", o_start, 0);
      tick();
      checkOutput("p1_load_busy", o_busy, 1);
      checkOutput("p1_load_start", o_start, 0);
      tick();
      checkOutput("p1_start", o_start, 1);
      checkOutput("p1_data", o_data, 8'h55);
      checkOutput("p1_mode", o_idle_mode, 2'b01);
      checkOutput("p1_sel0", o_sel_freq, 1);
      checkOutput("p1_popped_empty", o_empty, 1);
      tick();
      checkOutput("p1_start_one_clock", o_start, 0);
      for (int k = 1; k < 8; k++) begin
         applyStimulus(1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
         tick();
         quiet();
         checkOutput($sformatf("p1_sel%0d", k), o_sel_freq, 1);
      end
      applyStimulus(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0);
      tick();
      quiet();
      checkOutput("p1_done_tick", o_pkt_done_tick, 1);
      checkOutput("p1_gap_busy", o_busy, 1);
      checkOutput("p1_no_stop", o_stop, 0);
      tick();
      checkOutput("p1_done_one_clock", o_pkt_done_tick, 0);
      checkOutput("p1_gap2_busy", o_busy, 1);
      checkOutput("p1_gap_data_hold", o_data, 8'h55);
      tick();
      checkOutput("p1_idle", o_busy, 0);

      // Alternating speed mask 0x55
      applyStimulus(1'b1, 8'hAA, 8'h55, 2'b01, 1'b0, 1'b0, 1'b0);
      tick();
      quiet();
      tick();
      tick();
      checkOutput("p2_start", o_start, 1);
      checkOutput("p2_data", o_data, 8'hAA);
      checkOutput("p2_sel0", o_sel_freq, 1);
      m = 8'h55;
      for (int k = 1; k < 8; k++) begin
         applyStimulus(1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
         tick();
         quiet();
         checkOutput($sformatf("p2_sel%0d", k), o_sel_freq, m[k]);
         tick();
         checkOutput($sformatf("p2_hold%0d", k), o_sel_freq, m[k]);
      end
      applyStimulus(1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
      tick();
      quiet();
      checkOutput("p2_extra_tick_ignored", o_sel_freq, 0);
      applyStimulus(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0);
      tick();
      quiet();
      checkOutput("p2_done_tick", o_pkt_done_tick, 1);
      tick();
      tick();
      checkOutput("p2_idle", o_busy, 0);

      // Done tick in IDLE is ignored
      applyStimulus(1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b1, 1'b0);
      tick();
      quiet();
      checkOutput("idle_done_ignored", o_pkt_done_tick, 0);
      checkOutput("idle_busy", o_busy, 0);

      // Fill FIFO while a packet sits in SEND, overflow, then abort
      applyStimulus(1'b1, 8'h11, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
      tick();
      quiet();
      tick();
      tick();
      checkOutput("p3_start", o_start, 1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 8'(8'h20 + i), 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
         tick();
         if (i == 3) begin
            checkOutput("fill_full_after_4", o_full, 1);
            checkOutput("fill_count_4", o_count, 4);
            checkOutput("fill_no_err_4", o_wr_err, 0);
         end
      end
      quiet();
      checkOutput("fill_wr_err", o_wr_err, 1);
      checkOutput("fill_count_still_4", o_count, 4);
      checkOutput("fill_full_still", o_full, 1);
      tick();
      checkOutput("fill_wr_err_one_clock", o_wr_err, 0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
         tick();
      end
      applyStimulus(1'b1, 8'h99, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1);
      tick();
      quiet();
      checkOutput("abort_stop", o_stop, 1);
      checkOutput("abort_count", o_count, 0);
      checkOutput("abort_empty", o_empty, 1);
      checkOutput("abort_full", o_full, 0);
      checkOutput("abort_busy", o_busy, 0);
      checkOutput("abort_no_done", o_pkt_done_tick, 0);
      checkOutput("abort_no_wr_err", o_wr_err, 0);
      tick();
      checkOutput("abort_stop_one_clock", o_stop, 0);
      checkOutput("abort_stays_idle", o_busy, 0);

      // Repeat mode: repeats until a second command arrives
      applyStimulus(1'b1, 8'hC3, 8'h0E, 2'b11, 1'b0, 1'b0, 1'b0);
      tick();
      quiet();
      tick();
      tick();
      checkOutput("rep_start", o_start, 1);
      checkOutput("rep_sel0", o_sel_freq, 0);
      applyStimulus(1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
      tick();
      quiet();
      checkOutput("rep_sel1", o_sel_freq, 1);
      applyStimulus(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0);
      tick();
      quiet();
      checkOutput("rep_done1", o_pkt_done_tick, 1);
      checkOutput("rep_no_stop1", o_stop, 0);
      checkOutput("rep_still_busy", o_busy, 1);
      checkOutput("rep_sel_reset", o_sel_freq, 0);
      applyStimulus(1'b1, 8'h3C, 8'hF1, 2'b00, 1'b0, 1'b0, 1'b0);
      tick();
      quiet();
      checkOutput("rep_queued", o_count, 1);
      applyStimulus(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0);
      tick();
      quiet();
      checkOutput("rep_done2", o_pkt_done_tick, 1);
      checkOutput("rep_stop", o_stop, 1);
      checkOutput("rep_no_start_with_stop", o_start, 0);
      tick();
      checkOutput("rep_stop_one_clock", o_stop, 0);
      checkOutput("rep_gap_busy", o_busy, 1);
      checkOutput("rep_gap_data_hold", o_data, 8'hC3);
      tick();
      checkOutput("rep_idle", o_busy, 0);
      tick();
      tick();
      checkOutput("rep2_start", o_start, 1);
      checkOutput("rep2_data", o_data, 8'h3C);
      checkOutput("rep2_mode", o_idle_mode, 2'b00);
      checkOutput("rep2_sel0", o_sel_freq, 1);

      // Reset asserted mid-SEND with another command queued
      applyStimulus(1'b1, 8'h77, 8'hFF, 2'b10, 1'b0, 1'b0, 1'b0);
      tick();
      quiet();
      checkOutput("mid_count", o_count, 1);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_busy", o_busy, 0);
      checkOutput("mid_rst_empty", o_empty, 1);
      checkOutput("mid_rst_count", o_count, 0);
      checkOutput("mid_rst_data", o_data, 0);
      checkOutput("mid_rst_sel", o_sel_freq, 0);
      checkOutput("mid_rst_mode", o_idle_mode, 0);
      checkOutput("mid_rst_start", o_start, 0);
      tick();
      rst_n = 1'b1;
      tick();
      checkOutput("post_rst_start", o_start, 0);
      checkOutput("post_rst_stop", o_stop, 0);
      checkOutput("post_rst_done", o_pkt_done_tick, 0);
      checkOutput("post_rst_busy", o_busy, 0);
      tick();
      checkOutput("post_rst_stays_idle", o_busy, 0);
      checkOutput("post_rst_empty", o_empty, 1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/serial_cmd_scheduler.md
SERIAL_CMD_SCHEDULER -- requirements
Module: serial_cmd_scheduler

Interface
REQ-001 SHALL have parameter DATA_BIT, default 8, meaning bits per serial packet.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning number of command entries (power of 2, min 2).
REQ-003 SHALL have parameter GAP_CYCLES, default 2, meaning idle clocks between consecutive packets (min 1).
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_wr_en  input  1  push one command when high for one clock.
REQ-007 i_wr_data  input  DATA_BIT  packet payload.
REQ-008 i_wr_speed_mask  input  DATA_BIT  per-bit speed; bit k=1 selects high speed for k-th transmitted bit.
REQ-009 i_wr_idle_mode  input  2  00 low, 01 high, 10 keep, 11 repeat.
REQ-010 i_abort  input  1  cancel current packet and flush FIFO.
REQ-011 i_bit_tick  input  1  end-of-bit pulse from serial transmitter.
REQ-012 i_done_tick  input  1  end-of-packet pulse from serial transmitter.
REQ-013 o_start, o_stop  output  1 each  one-clock pulses to transmitter.
REQ-014 o_sel_freq  output  1  speed select for bit in progress.
REQ-015 o_data  output  DATA_BIT; o_idle_mode  output  2; held stable from o_start until packet ends.
REQ-016 o_full, o_empty  output  1 each; o_count  output  log2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-017 o_busy  output  1  high in any state except IDLE; o_pkt_done_tick  output  1  one-clock pulse per completed packet; o_wr_err  output  1  one-clock pulse on rejected write.

Function
REQ-018 FIFO SHALL store {data, speed_mask, idle_mode}; write accepted iff i_wr_en and !o_full evaluated before any same-cycle pop; rejected write SHALL pulse o_wr_err next clock and leave FIFO unchanged.
REQ-019 o_full/o_empty/o_count SHALL be registered, reflecting state after the current edge; pointers wrap modulo FIFO_DEPTH.
REQ-020 FSM states SHALL be IDLE, LOAD, SEND, GAP.
REQ-021 IDLE: if !o_empty -> LOAD; else stay.
REQ-022 LOAD (one clock): pop head into output registers, bit index=0, o_sel_freq=mask[0]; -> SEND with o_start high for exactly the first SEND clock.
REQ-023 SEND: each i_bit_tick with index<DATA_BIT-1 SHALL increment index and set o_sel_freq=mask[index+1] on that edge (visible one clock after tick); ticks at index DATA_BIT-1 ignored.
REQ-024 SEND, i_done_tick, idle_mode!=11: pulse o_pkt_done_tick, -> GAP.
REQ-025 SEND, i_done_tick, idle_mode=11: pulse o_pkt_done_tick; if FIFO non-empty pulse o_stop and -> GAP; else stay SEND, index=0, o_sel_freq=mask[0].
REQ-026 GAP: count GAP_CYCLES clocks then -> IDLE; o_data/o_idle_mode retain last values.
REQ-027 i_abort in any state SHALL flush FIFO (count 0) and -> IDLE next clock; if state was SEND, o_stop pulses one clock; no o_pkt_done_tick for aborted packet.
REQ-028 i_abort and i_wr_en same clock: abort wins, write discarded, no o_wr_err.
REQ-029 i_done_tick/i_bit_tick outside SEND SHALL be ignored.
REQ-030 o_start and o_stop SHALL never be high in the same clock.

Reset
REQ-031 rst_n low SHALL asynchronously force: state IDLE, FIFO empty (o_empty=1, o_full=0, o_count=0), o_start=o_stop=o_sel_freq=0, o_data=0, o_idle_mode=00, o_busy=0, o_pkt_done_tick=0, o_wr_err=0.
REQ-032 reset mid-packet SHALL discard all stored commands; no pulse outputs on reset release.

Verification
REQ-033 Push {8'h55, mask 8'hFF, 01} -> o_start 2 clocks after write, o_sel_freq=1 all bits, o_pkt_done_tick on done, IDLE after GAP_CYCLES.
REQ-034 Push {8'hAA, mask 8'h55, 01} -> o_sel_freq sequence 1,0,1,0,1,0,1,0, each change one clock after i_bit_tick.
REQ-035 Push 5 commands back-to-back (depth 4, idle) -> o_full after 4th, 5th pulses o_wr_err, o_count=4.
REQ-036 Push repeat-mode packet, then second packet after two i_done_tick -> two o_pkt_done_tick, then o_stop, GAP, o_start for second.
REQ-037 Assert i_abort after 3rd i_bit_tick with 2 queued -> o_stop one clock, o_count=0, IDLE, no o_pkt_done_tick.
REQ-038 Drop rst_n mid-SEND -> all outputs at reset values immediately, o_empty=1.
